// File: rtl/sync_hs_pkg.sv
// Shared types and default constants for the 4-phase handshake transmitter.
package sync_hs_pkg;

  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } hs_state_e;

endpackage

// File: rtl/sync_hs_fifo.sv
// Single-clock FIFO with registered pointers and level; head word is read
// directly from the array and captured by the consumer's own register.
module sync_hs_fifo
  import sync_hs_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              rstn_o,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic [LW-1:0]     level
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic              do_push;
  logic              do_pop;

  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign do_push = push && (level_reg != LW'(DEPTH));
  assign do_pop  = pop && (level_reg != '0);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk_i or posedge rstn_o) begin
    if (rstn_o) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/sync_hs_tx.sv
// Buffered initiator side of a 4-phase req/ack handshake into a synchronizer,
// with a sticky ack-timeout flag and a completed-transfer counter.
module sync_hs_tx
  import sync_hs_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rstn_o,
  input  logic              s_vld,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_rdy,
  output logic              hs_vld,
  output logic [DWIDTH-1:0] hs_data,
  input  logic              hs_ack,
  input  logic              err_clr,
  output logic              err,
  output logic [LW-1:0]     level,
  output logic [15:0]       sent_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  hs_state_e         state_reg;
  hs_state_e         state_next;
  logic [LW-1:0]     fifo_level;
  logic [DWIDTH-1:0] fifo_head;
  logic              fifo_pop;
  logic              load;
  logic              err_set;

  logic              hs_vld_reg;
  logic              hs_vld_next;
  logic [DWIDTH-1:0] hs_data_reg;
  logic [DWIDTH-1:0] hs_data_next;
  logic              err_reg;
  logic              err_next;
  logic [TW-1:0]     tmo_cnt_reg;
  logic [TW-1:0]     tmo_cnt_next;
  logic [15:0]       sent_cnt_reg;
  logic [15:0]       sent_cnt_next;

  assign s_rdy = (fifo_level != LW'(DEPTH));

  sync_hs_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_o (rstn_o),
    .push   (s_vld && s_rdy),
    .din    (s_data),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .level  (fifo_level)
  );

  // Reset lands in WAIT_LOW so an ack still high from before reset cannot
  // complete a freshly issued request.
  always_ff @(posedge clk_i or posedge rstn_o) begin
    if (rstn_o) begin
      state_reg <= ST_WAIT_LOW;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (fifo_level != '0) state_next = ST_REQ;
      ST_REQ:      if (hs_ack)           state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!hs_ack)          state_next = ST_IDLE;
      default:                           state_next = ST_WAIT_LOW;
    endcase
  end

  always_comb begin
    load          = (state_reg == ST_IDLE) && (state_next == ST_REQ);
    fifo_pop      = (state_reg == ST_REQ) && hs_ack;
    hs_vld_next   = (state_next == ST_REQ);
    hs_data_next  = load ? fifo_head : hs_data_reg;
    sent_cnt_next = fifo_pop ? sent_cnt_reg + 16'd1 : sent_cnt_reg;

    tmo_cnt_next = tmo_cnt_reg;
    if (load) begin
      tmo_cnt_next = '0;
    end else if ((state_reg == ST_REQ) && (tmo_cnt_reg != TW'(TIMEOUT))) begin
      tmo_cnt_next = tmo_cnt_reg + TW'(1);
    end

    // A set in the same cycle as err_clr wins.
    err_set  = (state_reg == ST_REQ) && (tmo_cnt_next == TW'(TIMEOUT));
    err_next = err_set || (err_reg && !err_clr);
  end

  always_ff @(posedge clk_i or posedge rstn_o) begin
    if (rstn_o) begin
      hs_vld_reg   <= 1'b0;
      hs_data_reg  <= '0;
      err_reg      <= 1'b0;
      tmo_cnt_reg  <= '0;
      sent_cnt_reg <= '0;
    end else begin
      hs_vld_reg   <= hs_vld_next;
      hs_data_reg  <= hs_data_next;
      err_reg      <= err_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      sent_cnt_reg <= sent_cnt_next;
    end
  end

  assign hs_vld   = hs_vld_reg;
  assign hs_data  = hs_data_reg;
  assign err      = err_reg;
  assign level    = fifo_level;
  assign sent_cnt = sent_cnt_reg;

endmodule

// File: tb/tb_sync_hs_tx.sv
// Scenario bench for sync_hs_tx: scoreboard of pushed words, modelled ack side.
`timescale 1ns/1ps
module tb_sync_hs_tx;

  logic        clk_i;
  logic        rstn_o;
  logic        s_vld;
  logic [7:0]  s_data;
  logic        s_rdy;
  logic        hs_vld;
  logic [7:0]  hs_data;
  logic        hs_ack;
  logic        err_clr;
  logic        err;
  logic [2:0]  level;
  logic [15:0] sent_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q[$];

  sync_hs_tx #(
    .DWIDTH  (8),
    .DEPTH   (4),
    .TIMEOUT (255)
  ) dut (
    .clk_i    (clk_i),
    .rstn_o   (rstn_o),
    .s_vld    (s_vld),
    .s_data   (s_data),
    .s_rdy    (s_rdy),
    .hs_vld   (hs_vld),
    .hs_data  (hs_data),
    .hs_ack   (hs_ack),
    .err_clr  (err_clr),
    .err      (err),
    .level    (level),
    .sent_cnt (sent_cnt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset(input logic ack_lvl);
    rstn_o  = 1'b1;
    s_vld   = 1'b0;
    s_data  = '0;
    hs_ack  = ack_lvl;
    err_clr = 1'b0;
    sb_q.delete();
    tick();
    tick();
    rstn_o = 1'b0;
    tick();
  endtask

  // Offers one word and holds it until accepted; expected word queued on acceptance.
  task automatic push_word(input logic [7:0] d);
    logic rdy;
    int   n;
    n      = 0;
    s_data = d;
    s_vld  = 1'b1;
    do begin
      rdy = s_rdy;
      tick();
      n++;
    end while (!rdy && n < 300);
    s_vld = 1'b0;
    total++;
    if (!rdy) begin
      bad++;
      $display("FAIL push_accept word=%02h s_rdy=%b required 1", d, rdy);
    end else begin
      sb_q.push_back(d);
    end
  endtask

  // Waits for a request, checks its word against the scoreboard, then acks it.
  task automatic ack_one(input int gap);
    int         n;
    logic [7:0] exp;
    n = 0;
    while (hs_vld !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (hs_vld !== 1'b1) begin
      bad++;
      $display("FAIL req_wait hs_vld=%b required 1", hs_vld);
      return;
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL sb_order hs_data=%02h required none (queue empty)", hs_data);
    end else begin
      exp = sb_q.pop_front();
      if (hs_data !== exp) begin
        bad++;
        $display("FAIL sb_order hs_data=%02h required %02h", hs_data, exp);
      end
    end
    repeat (gap) tick();
    hs_ack = 1'b1;
    tick();
    total++;
    if (hs_vld !== 1'b0) begin
      bad++;
      $display("FAIL ack_drop hs_vld=%b required 0", hs_vld);
    end
    $display("xfer word=%02h sent_cnt=%0d", hs_data, sent_cnt);
    hs_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn_o = 1'b1; s_vld = 1'b0; s_data = '0; hs_ack = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    total++;
    if ({hs_vld, hs_data, err, level, sent_cnt, s_rdy} !== {1'b0, 8'h00, 1'b0, 3'd0, 16'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state vld=%b data=%02h err=%b level=%0d sent=%0d rdy=%b required 0 00 0 0 0 1",
               hs_vld, hs_data, err, level, sent_cnt, s_rdy);
    end
    $display("reset checked");
  endtask

  task automatic test_single();
    apply_reset(1'b0);
    push_word(8'h5A);
    total++;
    if (hs_vld !== 1'b0 || level !== 3'd1) begin
      bad++;
      $display("FAIL single_push vld=%b level=%0d required 0 1", hs_vld, level);
    end
    tick();
    total++;
    if (hs_vld !== 1'b1 || hs_data !== 8'h5A) begin
      bad++;
      $display("FAIL single_req vld=%b data=%02h required 1 5a", hs_vld, hs_data);
    end
    ack_one(3);
    total++;
    if (sent_cnt !== 16'd1 || level !== 3'd0) begin
      bad++;
      $display("FAIL single_done sent=%0d level=%0d required 1 0", sent_cnt, level);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) push_word(8'(i));
    total++;
    if (level !== 3'd4 || s_rdy !== 1'b0) begin
      bad++;
      $display("FAIL full level=%0d s_rdy=%b required 4 0", level, s_rdy);
    end
    fork
      begin
        push_word(8'd4);
        push_word(8'd5);
      end
      begin
        repeat (6) ack_one(0);
      end
    join
    total++;
    if (sent_cnt !== 16'd6 || level !== 3'd0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_done sent=%0d level=%0d left=%0d required 6 0 0", sent_cnt, level, sb_q.size());
    end
  endtask

  task automatic test_timeout();
    apply_reset(1'b0);
    push_word(8'hA5);
    tick();
    void'(sb_q.pop_front());
    total++;
    if (hs_vld !== 1'b1 || hs_data !== 8'hA5) begin
      bad++;
      $display("FAIL tmo_req vld=%b data=%02h required 1 a5", hs_vld, hs_data);
    end
    repeat (254) tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_early err=%b required 0", err);
    end
    tick();
    total++;
    if (err !== 1'b1 || hs_vld !== 1'b1) begin
      bad++;
      $display("FAIL tmo_flag err=%b vld=%b required 1 1", err, hs_vld);
    end
    hs_ack = 1'b1;
    tick();
    total++;
    if (hs_vld !== 1'b0 || sent_cnt !== 16'd1 || err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_ack vld=%b sent=%0d err=%b required 0 1 1", hs_vld, sent_cnt, err);
    end
    hs_ack = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clr err=%b required 0", err);
    end
    // Clear arriving on the very cycle the flag is set must lose.
    push_word(8'h5B);
    tick();
    void'(sb_q.pop_front());
    repeat (254) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_set_wins err=%b required 1", err);
    end
    hs_ack = 1'b1;
    tick();
    hs_ack = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0 || sent_cnt !== 16'd2) begin
      bad++;
      $display("FAIL tmo_clr2 err=%b sent=%0d required 0 2", err, sent_cnt);
    end
    $display("timeout checked");
  endtask

  task automatic test_stale_ack();
    apply_reset(1'b0);
    push_word(8'h11);
    tick();
    hs_ack = 1'b1;
    #3;
    rstn_o = 1'b1;
    #1;
    total++;
    if (hs_vld !== 1'b0 || level !== 3'd0 || s_rdy !== 1'b1 || sent_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midreset vld=%b level=%0d rdy=%b sent=%0d required 0 0 1 0", hs_vld, level, s_rdy, sent_cnt);
    end
    sb_q.delete();
    tick();
    tick();
    rstn_o = 1'b0;
    tick();
    push_word(8'h3C);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (hs_vld !== 1'b0 || level !== 3'd1) begin
        bad++;
        $display("FAIL stale_hold cyc=%0d vld=%b level=%0d required 0 1", i, hs_vld, level);
      end
      tick();
    end
    hs_ack = 1'b0;
    tick();
    total++;
    if (hs_vld !== 1'b0) begin
      bad++;
      $display("FAIL stale_idle vld=%b required 0", hs_vld);
    end
    tick();
    total++;
    if (hs_vld !== 1'b1 || hs_data !== 8'h3C) begin
      bad++;
      $display("FAIL stale_req vld=%b data=%02h required 1 3c", hs_vld, hs_data);
    end
    ack_one(1);
    total++;
    if (sent_cnt !== 16'd1) begin
      bad++;
      $display("FAIL stale_done sent=%0d required 1", sent_cnt);
    end
  endtask

  task automatic test_random();
    apply_reset(1'b0);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          push_word(8'(i + 16));
        end
      end
      begin
        for (int k = 0; k < 40; k++) ack_one(int'($urandom_range(0, 4)));
      end
    join
    total++;
    if (sent_cnt !== 16'd40 || level !== 3'd0 || err !== 1'b0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL random_done sent=%0d level=%0d err=%b left=%0d required 40 0 0 0",
               sent_cnt, level, err, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_stale_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
